// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the SWT16 core.
// Drives the synchronous program memory address, hands each fetched word
// with its PC to the decoder, squashes wrong-path words after a jump and
// tracks two-word instructions so an immediate is never taken as an opcode.
//
// Optional feature macro: FETCH_HALT_EN. When it is defined, a standalone
// 16'hFFFF word halts fetch. When it is undefined, there is no HALT state
// and out_halted is tied low.
//
// Handshake: there is no valid/ready pair. A word on out_instr is live
// only in RUN. In every other state out_instr is NOP. While in_stall is
// high every visible output is frozen. in_jump is accepted in any cycle,
// including a stalled one.
module fetch_unit #(
   parameter int PMEM_ADDR_WIDTH = 12,
   parameter int PMEM_WORD_WIDTH = 16,
   parameter int PC_WIDTH        = 12,
   parameter int OPCODE_WIDTH    = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
   input  logic [PMEM_WORD_WIDTH-1:0] in_pmem_data,
   input  logic                       in_stall,
   input  logic                       in_jump,
   input  logic [PC_WIDTH-1:0]        in_jump_target,
   output logic [PMEM_WORD_WIDTH-1:0] out_instr,
   output logic [PC_WIDTH-1:0]        out_pc,
   output logic                       out_flush,
   output logic                       out_halted,
   output logic [2:0]                 debug_state
);

   typedef enum logic [2:0] {
      ST_BOOT   = 3'd0,
      ST_RUN    = 3'd1,
      ST_FLUSH1 = 3'd2,
      ST_FLUSH2 = 3'd3
`ifdef FETCH_HALT_EN
      ,
      ST_HALT   = 3'd4
`endif
   } state_t;

   state_t                       state, next_state;
   logic [PC_WIDTH-1:0]          pc;
   logic                         second_word;
   logic                         two_word;
   logic                         halt_hit;
   logic                         flush_q;
   logic                         held;
   logic [PMEM_WORD_WIDTH-1:0]   held_word;
`ifdef FETCH_HALT_EN
   logic                         halted_q;
`endif

   // A first word with opcode 0001 and bits[11:8] of 0 or 1 carries an immediate.
   assign two_word = (out_instr[OPCODE_WIDTH-1:0] == OPCODE_WIDTH'(1))
                     && (out_instr[11:9] == 3'b000);

`ifdef FETCH_HALT_EN
   // HALT is recognised only on a live first word.
   assign halt_hit = (state == ST_RUN) && (out_instr == '1) && !second_word;
`else
   assign halt_hit = 1'b0;
`endif

   // State register, plus registered flush/halted flags decoded from the next state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_BOOT;
         flush_q  <= 1'b0;
`ifdef FETCH_HALT_EN
         halted_q <= 1'b0;
`endif
      end else begin
         state    <= next_state;
         flush_q  <= (next_state == ST_FLUSH1) || (next_state == ST_FLUSH2);
`ifdef FETCH_HALT_EN
         halted_q <= (next_state == ST_HALT);
`endif
      end
   end

   // Next state: a jump always restarts the flush sequence, and a stall freezes everything else.
   always_comb begin
      next_state = state;
      if (in_jump) begin
         next_state = ST_FLUSH1;
      end else if (!in_stall) begin
         case (state)
            ST_BOOT:   next_state = ST_RUN;
`ifdef FETCH_HALT_EN
            ST_RUN:    next_state = halt_hit ? ST_HALT : ST_RUN;
`else
            ST_RUN:    next_state = ST_RUN;
`endif
            ST_FLUSH1: next_state = ST_FLUSH2;
            ST_FLUSH2: next_state = ST_RUN;
            default:   next_state = state;
         endcase
      end
   end

   // Datapath: PC, the address shown with the word, the second-word flag and the stall hold buffer.
   // FLUSH1 keeps the target address for a second cycle. Because of this, the
   // target word is read again and shows up on the third cycle after the jump.
   // During a stall the held address makes the memory return the next word,
   // so the word already on out_instr is captured in held_word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc          <= '0;
         out_pc      <= '0;
         second_word <= 1'b0;
         held        <= 1'b0;
         held_word   <= '0;
      end else if (in_jump) begin
         pc          <= in_jump_target;
         out_pc      <= pc;
         second_word <= 1'b0;
         held        <= 1'b0;
      end else if (in_stall) begin
         if (!held) begin
            held      <= 1'b1;
            held_word <= in_pmem_data;
         end
      end else begin
         held <= 1'b0;
         case (state)
            ST_RUN: begin
               if (!halt_hit) begin
                  pc          <= pc + 1'b1;
                  out_pc      <= pc;
                  second_word <= !second_word && two_word;
               end
            end
            ST_FLUSH1: begin
               out_pc      <= pc;
               second_word <= 1'b0;
            end
            ST_BOOT, ST_FLUSH2: begin
               pc          <= pc + 1'b1;
               out_pc      <= pc;
               second_word <= 1'b0;
            end
            default: begin
               pc <= pc;
            end
         endcase
      end
   end

   // Outputs: the word is live only in RUN, and the hold buffer covers the stall cycles.
   always_comb begin
      out_pmem_addr = pc;
      out_instr     = '0;
      if (state == ST_RUN) begin
         out_instr = held ? held_word : in_pmem_data;
      end
      out_flush     = flush_q;
`ifdef FETCH_HALT_EN
      out_halted    = halted_q;
`else
      out_halted    = 1'b0;
`endif
      debug_state   = state;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. It covers reset, sequential fetch, stall
// hold, the jump flush, wrap-around, a jump under stall, a jump restart
// during a flush, a stall inside a flush, two-word and FFFF handling, and
// an asynchronous mid-cycle reset.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] out_pmem_addr;
   logic [15:0] in_pmem_data = '0;
   logic        in_stall;
   logic        in_jump;
   logic [11:0] in_jump_target;
   logic [15:0] out_instr;
   logic [11:0] out_pc;
   logic        out_flush;
   logic        out_halted;
   logic [2:0]  debug_state;

   logic [15:0] mem [0:4095];
   int          n_cmp = 0;
   int          n_bad = 0;

   fetch_unit dut (
      .clock          (clock),
      .reset          (reset),
      .out_pmem_addr  (out_pmem_addr),
      .in_pmem_data   (in_pmem_data),
      .in_stall       (in_stall),
      .in_jump        (in_jump),
      .in_jump_target (in_jump_target),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_flush      (out_flush),
      .out_halted     (out_halted),
      .debug_state    (debug_state)
   );

   // clock and synchronous program memory model
   always #5 clock = ~clock;

   always @(posedge clock) in_pmem_data <= mem[out_pmem_addr];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [11:0] pc, input logic [15:0] instr);
      check({tag, ".pc"}, 32'(out_pc), 32'(pc));
      check({tag, ".instr"}, 32'(out_instr), 32'(instr));
      check({tag, ".flush"}, 32'(out_flush), 32'd0);
   endtask

   task automatic check_bubble(input string tag);
      check({tag, ".flush"}, 32'(out_flush), 32'd1);
      check({tag, ".instr"}, 32'(out_instr), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
      mem[12'h020] = 16'hFFFF;
      mem[12'h050] = 16'h0001;
      mem[12'h051] = 16'hFFFF;
      reset = 1'b1;
      in_stall = 1'b0;
      in_jump = 1'b0;
      in_jump_target = '0;

      // reset state
      tick();
      tick();
      check("rst.addr", 32'(out_pmem_addr), 32'd0);
      check("rst.instr", 32'(out_instr), 32'd0);
      check("rst.pc", 32'(out_pc), 32'd0);
      check("rst.flush", 32'(out_flush), 32'd0);
      check("rst.halted", 32'(out_halted), 32'd0);
      check("rst.state", 32'(debug_state), 32'd0);
      reset = 1'b0;
      check("boot.addr", 32'(out_pmem_addr), 32'd0);
      check("boot.instr", 32'(out_instr), 32'd0);

      // sequential fetch 0x000..0x010
      for (int i = 0; i <= 16; i++) begin
         tick();
         check_word("seq", 12'(i), 16'(i));
         check("seq.addr", 32'(out_pmem_addr), 32'(i + 1));
      end

      // stall for three cycles at 0x010
      in_stall = 1'b1;
      tick();
      check_word("stall1", 12'h010, 16'h0010);
      check("stall1.addr", 32'(out_pmem_addr), 32'h011);
      tick();
      check_word("stall2", 12'h010, 16'h0010);
      check("stall2.addr", 32'(out_pmem_addr), 32'h011);
      tick();
      check_word("stall3", 12'h010, 16'h0010);
      in_stall = 1'b0;
      tick();
      check_word("resume", 12'h011, 16'h0011);
      check("resume.addr", 32'(out_pmem_addr), 32'h012);
      tick();
      check_word("resume2", 12'h012, 16'h0012);

      // jump to 0x040: two bubbles, then the target word
      in_jump = 1'b1;
      in_jump_target = 12'h040;
      tick();
      in_jump = 1'b0;
      check_bubble("jmp.f1");
      check("jmp.f1.pc", 32'(out_pc), 32'h013);
      check("jmp.f1.addr", 32'(out_pmem_addr), 32'h040);
      tick();
      check_bubble("jmp.f2");
      tick();
      check_word("jmp.tgt", 12'h040, 16'h0040);
      check("jmp.tgt.addr", 32'(out_pmem_addr), 32'h041);

      // jump under stall to 0xFFE, then wrap
      in_stall = 1'b1;
      in_jump = 1'b1;
      in_jump_target = 12'hFFE;
      tick();
      in_stall = 1'b0;
      in_jump = 1'b0;
      check_bubble("jst.f1");
      check("jst.f1.addr", 32'(out_pmem_addr), 32'hFFE);
      tick();
      check_bubble("jst.f2");
      tick();
      check_word("wrap0", 12'hFFE, 16'h0FFE);
      tick();
      check_word("wrap1", 12'hFFF, 16'h0FFF);
      check("wrap1.addr", 32'(out_pmem_addr), 32'h000);
      tick();
      check_word("wrap2", 12'h000, 16'h0000);

      // jump, then a second jump in FLUSH1, then a stall in FLUSH2
      in_jump = 1'b1;
      in_jump_target = 12'h080;
      tick();
      check_bubble("rj.f1");
      check("rj.f1.addr", 32'(out_pmem_addr), 32'h080);
      in_jump_target = 12'h0A0;
      tick();
      in_jump = 1'b0;
      check_bubble("rj.f1b");
      check("rj.f1b.addr", 32'(out_pmem_addr), 32'h0A0);
      tick();
      check_bubble("rj.f2");
      in_stall = 1'b1;
      tick();
      check_bubble("rj.f2stall");
      in_stall = 1'b0;
      tick();
      check_word("rj.tgt", 12'h0A0, 16'h00A0);
      tick();
      check_word("rj.next", 12'h0A1, 16'h00A1);

      // two-word instruction: its immediate FFFF is not a halt
      in_jump = 1'b1;
      in_jump_target = 12'h050;
      tick();
      in_jump = 1'b0;
      tick();
      tick();
      check_word("tw.first", 12'h050, 16'h0001);
      tick();
      check_word("tw.imm", 12'h051, 16'hFFFF);
      tick();
      check_word("tw.after", 12'h052, 16'h0052);
      check("tw.halted", 32'(out_halted), 32'd0);
      check("tw.addr", 32'(out_pmem_addr), 32'h053);

      // standalone FFFF at 0x020
      in_jump = 1'b1;
      in_jump_target = 12'h020;
      tick();
      in_jump = 1'b0;
      tick();
      tick();
      check_word("ff.word", 12'h020, 16'hFFFF);
      check("ff.halted0", 32'(out_halted), 32'd0);
      check("ff.addr", 32'(out_pmem_addr), 32'h021);
`ifdef FETCH_HALT_EN
      tick();
      check("halt.halted", 32'(out_halted), 32'd1);
      check("halt.instr", 32'(out_instr), 32'd0);
      check("halt.addr", 32'(out_pmem_addr), 32'h021);
      tick();
      check("halt2.halted", 32'(out_halted), 32'd1);
      check("halt2.addr", 32'(out_pmem_addr), 32'h021);
      check("halt2.instr", 32'(out_instr), 32'd0);
      in_jump = 1'b1;
      in_jump_target = 12'h030;
      tick();
      in_jump = 1'b0;
      check_bubble("hj.f1");
      check("hj.f1.halted", 32'(out_halted), 32'd0);
      tick();
      tick();
      check_word("hj.tgt", 12'h030, 16'h0030);
      check("hj.halted", 32'(out_halted), 32'd0);
`else
      tick();
      check_word("ff.next", 12'h021, 16'h0021);
      check("ff.halted1", 32'(out_halted), 32'd0);
      check("ff.next.addr", 32'(out_pmem_addr), 32'h022);
`endif

      // asynchronous reset in the middle of a cycle
      #2;
      reset = 1'b1;
      #1;
      check("areset.addr", 32'(out_pmem_addr), 32'd0);
      check("areset.instr", 32'(out_instr), 32'd0);
      check("areset.pc", 32'(out_pc), 32'd0);
      check("areset.flush", 32'(out_flush), 32'd0);
      tick();
      reset = 1'b0;
      check("reboot.instr", 32'(out_instr), 32'd0);
      tick();
      check_word("reboot.w0", 12'h000, 16'h0000);
      check("reboot.addr", 32'(out_pmem_addr), 32'h001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
